pfc_quad_encoder: RTL and testbench

//  PFC-side peripheral hanging off the pfcif command/response port: decodes the 37-bit

---
 rtl/pfc_qenc_pkg.sv | 44 ++++
 rtl/pfc_qenc_channel.sv | 109 ++++++++++
 rtl/pfc_quad_encoder.sv | 110 +++++++++++
 tb/tb_pfc_quad_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pfc_qenc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pfc_qenc_pkg
// Description : Shared definitions for the PFC quadrature encoder peripheral:
//               pfcif command op codes, register addresses, ID constant,
//               command field positions and the Gray-to-phase helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pfc_qenc_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [2:0] ADDR_COUNT0 = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_RSVD   = 3'd6;
    localparam logic [2:0] ADDR_ID     = 3'd7;

    localparam logic [31:0] ID_VALUE = 32'h51454E43;

    localparam int CMD_W       = 37;
    localparam int CMD_OP_HI   = 36;
    localparam int CMD_OP_LO   = 35;
    localparam int CMD_ADDR_HI = 34;
    localparam int CMD_ADDR_LO = 32;
    localparam int CMD_DATA_HI = 31;
    localparam int CMD_DATA_LO = 0;

    localparam int CTRL_INV_LSB = 8;

    // Map a filtered {A,B} level onto its position in the quadrature cycle
    // 00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3 so a step is a modular difference.
    function automatic logic [1:0] gray_to_phase(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pfc_qenc_channel.sv
`default_nettype none
// ============================================================================
// Module      : pfc_qenc_channel
// Description : One quadrature channel: 2-FF synchroniser, stability filter,
//               Gray-step decoder, 32-bit position counter, sticky error flag.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_enc_a, i_enc_b    - asynchronous encoder phases
//               i_enable, i_invert  - count enable, direction invert
//               i_preset_we/_data   - load counter (wins over a step)
//               i_err_clr           - clear error flag (loses to a new error)
//               o_count, o_err      - live count and sticky error
// Revision    : 1.0 - initial release
// ============================================================================
module pfc_qenc_channel
    import pfc_qenc_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enc_a,
    input  logic        i_enc_b,
    input  logic        i_enable,
    input  logic        i_invert,
    input  logic        i_preset_we,
    input  logic [31:0] i_preset_data,
    input  logic        i_err_clr,
    output logic [31:0] o_count,
    output logic        o_err
);

    localparam logic [3:0] c_filter_len = 4'(FILTER_LEN);

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_cand;
    logic [3:0]  r_run;
    logic [1:0]  r_filt;
    logic        r_primed;
    logic [31:0] r_count;
    logic        r_err;

    logic [3:0]  w_run;
    logic        w_accept;
    logic        w_valid;
    logic [1:0]  w_delta;
    logic        w_fwd;
    logic        w_rev;
    logic        w_illegal;
    logic        w_up;
    logic        w_dn;

    always_comb begin
        // Length of the run of identical synchronised samples including this
        // one; saturates so a long-stable level never re-triggers acceptance.
        w_run = 4'd1;
        if (r_sync2 == r_cand) begin
            w_run = (r_run == c_filter_len) ? r_run : r_run + 4'd1;
        end
        // Until primed there is no current level, so any stable run is taken.
        w_accept  = (w_run == c_filter_len) && (!r_primed || (r_sync2 != r_filt));
        w_valid   = w_accept && r_primed;
        w_delta   = gray_to_phase(r_sync2) - gray_to_phase(r_filt);
        w_fwd     = w_valid && (w_delta == 2'd1);
        w_rev     = w_valid && (w_delta == 2'd3);
        w_illegal = w_valid && (w_delta == 2'd2);
        w_up      = i_invert ? w_rev : w_fwd;
        w_dn      = i_invert ? w_fwd : w_rev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_cand   <= 2'b00;
            r_run    <= 4'd0;
            r_filt   <= 2'b00;
            r_primed <= 1'b0;
            r_count  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_sync1 <= {i_enc_a, i_enc_b};
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_run   <= w_run;
            if (w_accept) begin
                r_filt   <= r_sync2;
                r_primed <= 1'b1;
            end
            if (i_preset_we) begin
                r_count <= i_preset_data;
            end else if (i_enable && w_up) begin
                r_count <= r_count + 32'd1;
            end else if (i_enable && w_dn) begin
                r_count <= r_count - 32'd1;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/pfc_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : pfc_quad_encoder
// Description : pfcif peripheral with CHANNELS quadrature decoders. Decodes
//               the 37-bit command bus into register accesses and returns
//               registered 32-bit read data.
// Ports       : pfc_clk, pfc_reset  - clock, synchronous active-high reset
//               pfc_cmd [36:0]      - {op[1:0], addr[2:0], wdata[31:0]}
//               pfc_resp[31:0]      - read data, updated only by reads
//               enc_a, enc_b        - asynchronous encoder phases
//               enc_err             - sticky illegal-transition flags
// Revision    : 1.0 - initial release
// ============================================================================
module pfc_quad_encoder
    import pfc_qenc_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int FILTER_LEN = 4
) (
    input  logic                pfc_clk,
    input  logic                pfc_reset,
    input  logic [CMD_W-1:0]    pfc_cmd,
    output logic [31:0]         pfc_resp,
    input  logic [CHANNELS-1:0] enc_a,
    input  logic [CHANNELS-1:0] enc_b,
    output logic [CHANNELS-1:0] enc_err
);

    op_e                w_op;
    logic [2:0]         w_addr;
    logic [31:0]        w_wdata;
    logic               w_wr;
    logic               w_rd;
    logic [31:0]        w_count [CHANNELS];
    logic [CHANNELS-1:0] w_err;
    logic [31:0]        w_rdata;

    logic [CHANNELS-1:0] r_ctrl_en;
    logic [CHANNELS-1:0] r_ctrl_inv;
    logic [31:0]         r_resp;

    // Reserved op 11 falls through as idle because it matches neither decode.
    assign w_op    = op_e'(pfc_cmd[CMD_OP_HI:CMD_OP_LO]);
    assign w_addr  = pfc_cmd[CMD_ADDR_HI:CMD_ADDR_LO];
    assign w_wdata = pfc_cmd[CMD_DATA_HI:CMD_DATA_LO];
    assign w_wr    = (w_op == OP_WRITE);
    assign w_rd    = (w_op == OP_READ);

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            pfc_qenc_channel #(
                .FILTER_LEN (FILTER_LEN)
            ) u_chan (
                .clk           (pfc_clk),
                .rst           (pfc_reset),
                .i_enc_a       (enc_a[c]),
                .i_enc_b       (enc_b[c]),
                .i_enable      (r_ctrl_en[c]),
                .i_invert      (r_ctrl_inv[c]),
                .i_preset_we   (w_wr && (w_addr == 3'(c))),
                .i_preset_data (w_wdata),
                .i_err_clr     (w_wr && (w_addr == ADDR_STATUS) && w_wdata[c]),
                .o_count       (w_count[c]),
                .o_err         (w_err[c])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            ADDR_STATUS: w_rdata[CHANNELS-1:0] = w_err;
            ADDR_CTRL: begin
                w_rdata[CHANNELS-1:0]               = r_ctrl_en;
                w_rdata[CTRL_INV_LSB +: CHANNELS]   = r_ctrl_inv;
            end
            ADDR_ID:   w_rdata = ID_VALUE;
            ADDR_RSVD: w_rdata = 32'd0;
            default: begin
                // COUNT slots without a channel behind them read as zero.
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_addr == 3'(c)) begin
                        w_rdata = w_count[c];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pfc_clk) begin
        if (pfc_reset) begin
            r_ctrl_en  <= '0;
            r_ctrl_inv <= '0;
            r_resp     <= 32'd0;
        end else begin
            if (w_wr && (w_addr == ADDR_CTRL)) begin
                r_ctrl_en  <= w_wdata[CHANNELS-1:0];
                r_ctrl_inv <= w_wdata[CTRL_INV_LSB +: CHANNELS];
            end
            if (w_rd) begin
                r_resp <= w_rdata;
            end
        end
    end

    assign pfc_resp = r_resp;
    assign enc_err  = w_err;

endmodule
`default_nettype wire

// File: tb/tb_pfc_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pfc_quad_encoder
// Description : Self-checking bench for pfc_quad_encoder: register-access
//               vector table plus directed encoder rotation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pfc_quad_encoder;

    localparam logic [1:0] c_rd = 2'b01;
    localparam logic [1:0] c_wr = 2'b10;
    localparam logic [1:0] c_rs = 2'b11;
    localparam logic [31:0] c_id = 32'h51454E43;

    logic        pfc_clk = 1'b0;
    logic        pfc_reset;
    logic [36:0] pfc_cmd;
    logic [31:0] pfc_resp;
    logic [3:0]  enc_a;
    logic [3:0]  enc_b;
    logic [3:0]  enc_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [21];

    always #5 pfc_clk = ~pfc_clk;

    pfc_quad_encoder #(
        .CHANNELS   (4),
        .FILTER_LEN (4)
    ) dut (
        .pfc_clk   (pfc_clk),
        .pfc_reset (pfc_reset),
        .pfc_cmd   (pfc_cmd),
        .pfc_resp  (pfc_resp),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_err   (enc_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge pfc_clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [2:0] addr, input logic [31:0] d);
        pfc_cmd = {op, addr, d};
        @(posedge pfc_clk);
        #1;
        pfc_cmd = '0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
        cmd(c_rd, addr, 32'd0);
        check(name, pfc_resp, exp);
    endtask

    task automatic set_ch(input int ch, input logic [1:0] ab);
        enc_a[ch] = ab[1];
        enc_b[ch] = ab[0];
    endtask

    task automatic step_ch(input int ch, input logic [1:0] ab);
        set_ch(ch, ab);
        cycles(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{c_rd, 3'd7, 32'h0,        c_id};
        vecs[1]  = '{c_rd, 3'd0, 32'h0,        32'h0};
        vecs[2]  = '{c_rd, 3'd1, 32'h0,        32'h0};
        vecs[3]  = '{c_rd, 3'd2, 32'h0,        32'h0};
        vecs[4]  = '{c_rd, 3'd3, 32'h0,        32'h0};
        vecs[5]  = '{c_rd, 3'd4, 32'h0,        32'h0};
        vecs[6]  = '{c_rd, 3'd5, 32'h0,        32'h0};
        vecs[7]  = '{c_rd, 3'd6, 32'h0,        32'h0};
        vecs[8]  = '{c_wr, 3'd7, 32'h12345678, 32'h0};
        vecs[9]  = '{c_rd, 3'd7, 32'h0,        c_id};
        vecs[10] = '{c_wr, 3'd5, 32'hFFFFFFFF, 32'h0};
        vecs[11] = '{c_rd, 3'd5, 32'h0,        32'h00000F0F};
        vecs[12] = '{c_wr, 3'd5, 32'h0,        32'h0};
        vecs[13] = '{c_rd, 3'd5, 32'h0,        32'h0};
        vecs[14] = '{c_wr, 3'd2, 32'h00000055, 32'h0};
        vecs[15] = '{c_rd, 3'd2, 32'h0,        32'h00000055};
        vecs[16] = '{c_wr, 3'd2, 32'h0,        32'h0};
        vecs[17] = '{c_rs, 3'd1, 32'h00000005, 32'h0};
        vecs[18] = '{c_rd, 3'd1, 32'h0,        32'h0};
        vecs[19] = '{c_wr, 3'd6, 32'hFFFFFFFF, 32'h0};
        vecs[20] = '{c_rd, 3'd6, 32'h0,        32'h0};

        pfc_reset = 1'b1;
        pfc_cmd   = '0;
        enc_a     = '0;
        enc_b     = '0;
        cycles(3);
        check("reset_resp", pfc_resp, 32'h0);
        check("reset_enc_err", 32'(enc_err), 32'h0);
        pfc_reset = 1'b0;
        cycles(10);

        // Register access table
        for (int i = 0; i < 21; i++) begin
            cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
            if (vecs[i].op == c_rd) begin
                check($sformatf("vec%0d", i), pfc_resp, vecs[i].exp);
            end
        end

        // Read data holds across a non-read command
        rd_check("id_read", 3'd7, c_id);
        cmd(c_wr, 3'd5, 32'h0);
        check("resp_hold", pfc_resp, c_id);

        // Channel 0 forward then reverse
        cmd(c_wr, 3'd5, 32'h1);
        step_ch(0, 2'b01);
        step_ch(0, 2'b11);
        rd_check("ch0_fwd2", 3'd0, 32'd2);
        step_ch(0, 2'b10);
        step_ch(0, 2'b00);
        rd_check("ch0_fwd4", 3'd0, 32'd4);
        step_ch(0, 2'b10);
        step_ch(0, 2'b11);
        step_ch(0, 2'b01);
        step_ch(0, 2'b00);
        rd_check("ch0_rev4", 3'd0, 32'd0);

        // Modular wrap in both directions
        cmd(c_wr, 3'd0, 32'hFFFFFFFF);
        step_ch(0, 2'b01);
        rd_check("ch0_wrap_up", 3'd0, 32'h0);
        step_ch(0, 2'b00);
        rd_check("ch0_wrap_dn", 3'd0, 32'hFFFFFFFF);

        // Channel 1 inverted
        cmd(c_wr, 3'd5, 32'h00000203);
        step_ch(1, 2'b01);
        step_ch(1, 2'b11);
        step_ch(1, 2'b10);
        step_ch(1, 2'b00);
        rd_check("ch1_inv_fwd4", 3'd1, 32'hFFFFFFFC);
        cmd(c_wr, 3'd1, 32'h7FFFFFFF);
        step_ch(1, 2'b10);
        rd_check("ch1_overflow", 3'd1, 32'h80000000);
        step_ch(1, 2'b00);
        rd_check("ch1_back", 3'd1, 32'h7FFFFFFF);

        // Channel 2 glitch rejection, then a genuine step
        cmd(c_wr, 3'd5, 32'h00000207);
        enc_a[2] = 1'b1;
        cycles(3);
        enc_a[2] = 1'b0;
        cycles(10);
        rd_check("ch2_glitch_cnt", 3'd2, 32'h0);
        rd_check("ch2_glitch_status", 3'd4, 32'h0);
        step_ch(2, 2'b10);
        rd_check("ch2_rev1", 3'd2, 32'hFFFFFFFF);
        step_ch(2, 2'b00);
        rd_check("ch2_fwd1", 3'd2, 32'h0);

        // Channel 3 illegal transition and W1C
        cmd(c_wr, 3'd5, 32'h0000020F);
        set_ch(3, 2'b11);
        cycles(10);
        rd_check("ch3_status_set", 3'd4, 32'h8);
        check("ch3_enc_err_set", 32'(enc_err), 32'h8);
        rd_check("ch3_cnt", 3'd3, 32'h0);
        cmd(c_wr, 3'd4, 32'h8);
        rd_check("ch3_status_clr", 3'd4, 32'h0);
        check("ch3_enc_err_clr", 32'(enc_err), 32'h0);
        // W1C lands on the edge the illegal 11->00 is accepted
        set_ch(3, 2'b00);
        cycles(5);
        cmd(c_wr, 3'd4, 32'h8);
        cycles(2);
        rd_check("ch3_set_wins", 3'd4, 32'h8);
        rd_check("ch3_cnt2", 3'd3, 32'h0);

        // Preset coincident with a +1 step on channel 0 (count FFFFFFFF, at 00)
        set_ch(0, 2'b01);
        cycles(5);
        cmd(c_wr, 3'd0, 32'd100);
        cycles(4);
        rd_check("ch0_preset_wins", 3'd0, 32'd100);
        step_ch(0, 2'b11);
        rd_check("ch0_after_preset", 3'd0, 32'd101);

        // Reset mid-operation with a pending write; inputs left at 11
        pfc_reset = 1'b1;
        pfc_cmd   = {c_wr, 3'd1, 32'h5};
        @(posedge pfc_clk);
        #1;
        pfc_cmd = '0;
        check("midreset_resp", pfc_resp, 32'h0);
        check("midreset_enc_err", 32'(enc_err), 32'h0);
        cycles(1);
        pfc_reset = 1'b0;
        cycles(12);
        rd_check("post_reset_cnt0", 3'd0, 32'h0);
        rd_check("post_reset_cnt1", 3'd1, 32'h0);
        rd_check("post_reset_status", 3'd4, 32'h0);
        rd_check("post_reset_ctrl", 3'd5, 32'h0);
        check("post_reset_enc_err", 32'(enc_err), 32'h0);
        cmd(c_wr, 3'd5, 32'h1);
        cycles(10);
        rd_check("post_reset_prime", 3'd0, 32'h0);
        step_ch(0, 2'b10);
        rd_check("post_reset_step", 3'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
